// File: rtl/erx_cal_pkg.sv
// Shared definitions for the elink RX IDELAY training controller:
// FSM state encoding, default lane/tap geometry and window-centre helper.
package erx_cal_pkg;

    localparam int NL_DEF  = 9;
    localparam int TW_DEF  = 5;
    localparam int TAP_MAX = (1 << TW_DEF) - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_CHECK,
        ST_UPDATE,
        ST_FINAL,
        ST_APPLY,
        ST_DONE
    } cal_state_e;

    // Centre of a window; an empty window parks the lane at tap 0.
    function automatic logic [31:0] center(input logic [31:0] start, input logic [31:0] len);
        return (len == 32'd0) ? 32'd0 : start + (len >> 1);
    endfunction

endpackage

// File: rtl/erx_cal_window.sv
// One lane's passing-window tracker: follows the current run of passing taps
// and keeps the widest run seen (ties keep the lowest-tap window).
module erx_cal_window
    import erx_cal_pkg::*;
#(
    parameter int TW = TW_DEF
)(
    input  logic          clk,
    input  logic          nreset,
    input  logic          i_clear,
    input  logic          i_update,
    input  logic          i_final,
    input  logic          i_pass,
    input  logic [TW-1:0] i_tap,
    output logic [TW-1:0] o_best_start,
    output logic [TW:0]   o_best_len
);

    logic [TW-1:0] r_run_start;
    logic [TW-1:0] r_best_start;
    logic [TW:0]   r_run_len;
    logic [TW:0]   r_best_len;
    logic          w_run_wins;

    assign w_run_wins = r_run_len > r_best_len;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_run_start  <= '0;
            r_run_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
        end else if (i_clear) begin
            r_run_start  <= '0;
            r_run_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
        end else if (i_update && i_pass) begin
            if (r_run_len == '0) begin
                r_run_start <= i_tap;
            end
            r_run_len <= r_run_len + 1'b1;
        end else if (i_update || i_final) begin
            if (w_run_wins) begin
                r_best_start <= r_run_start;
                r_best_len   <= r_run_len;
            end
            r_run_len <= '0;
        end
    end

    // Report the open run too, so the result is already final while FINAL closes it.
    assign o_best_start = w_run_wins ? r_run_start : r_best_start;
    assign o_best_len   = w_run_wins ? r_run_len   : r_best_len;

endmodule

// File: rtl/erx_idelay_cal.sv
// Elink RX IDELAY training controller: sweeps a shared tap over all lanes and
// loads each lane's widest-window centre. Optional ERX_IDELAY_CAL_OVERRIDE_EN adds manual tap override.
module erx_idelay_cal
    import erx_cal_pkg::*;
#(
    parameter int         NL      = NL_DEF,
    parameter int         TW      = TW_DEF,
    parameter int         SETTLE  = 8,
    parameter int         SAMPLES = 16,
    parameter logic [7:0] PATTERN = 8'h55,
    parameter int         MIN_EYE = 4
)(
    input  logic             clk,
    input  logic             nreset,
    input  logic             cal_start,
    input  logic             cal_valid,
    input  logic [NL*8-1:0]  cal_data,
`ifdef ERX_IDELAY_CAL_OVERRIDE_EN
    input  logic             ovr_en,
    input  logic [NL*TW-1:0] ovr_taps,
`endif
    output logic [NL*TW-1:0] idelay_value,
    output logic             load_taps,
    output logic             cal_busy,
    output logic             cal_done,
    output logic [NL-1:0]    cal_fail
);

    localparam int            CW       = $clog2((SETTLE > SAMPLES) ? SETTLE : SAMPLES) + 1;
    localparam logic [TW-1:0] LAST_TAP = {TW{1'b1}};

    cal_state_e       r_state;
    logic [TW-1:0]    r_tap;
    logic [CW-1:0]    r_cnt;
    logic [NL-1:0]    r_err;
    logic [NL*TW-1:0] r_idelay;
    logic             r_load_taps;
    logic             r_busy;
    logic             r_done;
    logic [NL-1:0]    r_cal_fail;
`ifdef ERX_IDELAY_CAL_OVERRIDE_EN
    logic             r_ovr_d;
`endif

    logic             w_start_ok;
    logic             w_update;
    logic             w_final;
    logic [TW-1:0]    w_tap_next;
    logic [NL-1:0]    w_mismatch;
    logic [NL-1:0]    w_eye_short;
    logic [NL*TW-1:0] w_center;
    logic [TW-1:0]    w_best_start [NL];
    logic [TW:0]      w_best_len   [NL];

    assign w_start_ok = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && cal_start;
    assign w_update   = (r_state == ST_UPDATE);
    assign w_final    = (r_state == ST_FINAL);
    assign w_tap_next = r_tap + 1'b1;

    always_comb begin
        w_mismatch  = '0;
        w_eye_short = '0;
        w_center    = '0;
        for (int k = 0; k < NL; k++) begin
            w_mismatch[k]          = (cal_data[8*k +: 8] != PATTERN);
            w_eye_short[k]         = (w_best_len[k] < (TW+1)'(MIN_EYE));
            w_center[TW*k +: TW]   = TW'(center(32'(w_best_start[k]), 32'(w_best_len[k])));
        end
    end

    for (genvar g = 0; g < NL; g++) begin : g_lane
        erx_cal_window #(.TW(TW)) u_window (
            .clk          (clk),
            .nreset       (nreset),
            .i_clear      (w_start_ok),
            .i_update     (w_update),
            .i_final      (w_final),
            .i_pass       (~r_err[g]),
            .i_tap        (r_tap),
            .o_best_start (w_best_start[g]),
            .o_best_len   (w_best_len[g])
        );
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state     <= ST_IDLE;
            r_tap       <= '0;
            r_cnt       <= '0;
            r_err       <= '0;
            r_idelay    <= '0;
            r_load_taps <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cal_fail  <= '0;
`ifdef ERX_IDELAY_CAL_OVERRIDE_EN
            r_ovr_d     <= 1'b0;
`endif
        end else begin
            r_load_taps <= 1'b0;
`ifdef ERX_IDELAY_CAL_OVERRIDE_EN
            r_ovr_d     <= ovr_en;
`endif
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (cal_start) begin
                        r_state     <= ST_LOAD;
                        r_tap       <= '0;
                        r_idelay    <= '0;
                        r_load_taps <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                    end
`ifdef ERX_IDELAY_CAL_OVERRIDE_EN
                    else if (ovr_en && !r_ovr_d) begin
                        r_idelay    <= ovr_taps;
                        r_load_taps <= 1'b1;
                        r_cal_fail  <= '0;
                    end
`endif
                end
                ST_LOAD: begin
                    r_err   <= '0;
                    r_cnt   <= '0;
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_cnt == CW'(SETTLE - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_CHECK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (cal_valid) begin
                        r_err <= r_err | w_mismatch;
                        if (r_cnt == CW'(SAMPLES - 1)) begin
                            r_cnt   <= '0;
                            r_state <= ST_UPDATE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_UPDATE: begin
                    if (r_tap == LAST_TAP) begin
                        r_state <= ST_FINAL;
                    end else begin
                        r_tap       <= w_tap_next;
                        r_idelay    <= {NL{w_tap_next}};
                        r_load_taps <= 1'b1;
                        r_state     <= ST_LOAD;
                    end
                end
                ST_FINAL: begin
                    r_idelay    <= w_center;
                    r_cal_fail  <= w_eye_short;
                    r_load_taps <= 1'b1;
                    r_state     <= ST_APPLY;
                end
                ST_APPLY: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign idelay_value = r_idelay;
    assign load_taps    = r_load_taps;
    assign cal_busy     = r_busy;
    assign cal_done     = r_done;
    assign cal_fail     = r_cal_fail;

endmodule

// File: tb/tb_erx_idelay_cal.sv
// Scoreboard bench for erx_idelay_cal: a channel model returns the training byte
// per lane from a pass mask; expected taps come from a plain widest-window search.
module tb_erx_idelay_cal;
    import erx_cal_pkg::*;

    localparam int NL = 9;
    localparam int TW = 5;
    localparam int NT = TAP_MAX + 1;

    typedef struct packed {
        logic [NL*TW-1:0] taps;
        logic [NL-1:0]    fail;
        logic             timed;
    } exp_t;

    logic             clk = 1'b0;
    logic             nreset;
    logic             cal_start;
    logic             cal_valid;
    logic [NL*8-1:0]  cal_data;
    logic [NL*TW-1:0] idelay_value;
    logic             load_taps;
    logic             cal_busy;
    logic             cal_done;
    logic [NL-1:0]    cal_fail;
`ifdef ERX_IDELAY_CAL_OVERRIDE_EN
    logic             ovr_en = 1'b0;
    logic [NL*TW-1:0] ovr_taps = '0;
`endif

    exp_t          sb[$];
    exp_t          e;
    int            checks = 0;
    int            passes = 0;
    logic [31:0]   pass_mask [NL];
    int            valid_pct = 100;
    logic [TW-1:0] ch_tap [NL];
    int            glitch = 0;

    int   cyc = 0;
    int   start_cyc = 0;
    int   pulses = 0;
    logic prev_load = 1'b0;
    logic back2back = 1'b0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    erx_idelay_cal dut (
        .clk          (clk),
        .nreset       (nreset),
        .cal_start    (cal_start),
        .cal_valid    (cal_valid),
        .cal_data     (cal_data),
`ifdef ERX_IDELAY_CAL_OVERRIDE_EN
        .ovr_en       (ovr_en),
        .ovr_taps     (ovr_taps),
`endif
        .idelay_value (idelay_value),
        .load_taps    (load_taps),
        .cal_busy     (cal_busy),
        .cal_done     (cal_done),
        .cal_fail     (cal_fail)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] win(input int lo, input int hi);
        logic [31:0] m = '0;
        for (int i = lo; i <= hi && i < NT; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Widest run of ones; a later run must be strictly longer to win.
    function automatic void refWindow(input logic [31:0] m, output int bs, output int bl);
        bs = 0;
        bl = 0;
        for (int s = 0; s < NT; s++) begin
            if (m[s] && (s == 0 || m[s-1] == 1'b0)) begin
                int n = 0;
                while (s + n < NT && m[s+n]) n++;
                if (n > bl) begin
                    bl = n;
                    bs = s;
                end
            end
        end
    endfunction

    function automatic exp_t modelSweep();
        exp_t r;
        int bs, bl;
        r = '0;
        for (int k = 0; k < NL; k++) begin
            refWindow(pass_mask[k], bs, bl);
            r.taps[TW*k +: TW] = (bl == 0) ? '0 : TW'(bs + bl / 2);
            r.fail[k] = (bl < 4);
        end
        r.timed = (valid_pct == 100);
        return r;
    endfunction

    // Delay-line model: lanes latch their tap on a load strobe and glitch briefly afterwards.
    always @(posedge clk) begin
        #1;
        if (load_taps) begin
            for (int k = 0; k < NL; k++) ch_tap[k] = idelay_value[TW*k +: TW];
            glitch = 4;
        end else if (glitch > 0) begin
            glitch--;
        end
    end

    always @(negedge clk) begin
        cal_valid = ($urandom_range(1, 100) <= valid_pct);
        for (int k = 0; k < NL; k++) begin
            if (glitch > 0 || !cal_valid) cal_data[8*k +: 8] = 8'($urandom);
            else if (pass_mask[k][ch_tap[k]]) cal_data[8*k +: 8] = 8'h55;
            else cal_data[8*k +: 8] = 8'h55 ^ 8'($urandom_range(1, 255));
        end
    end

    // Monitor: pops one expectation each time cal_done rises.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!nreset) begin
            prev_done = 1'b0;
            prev_load = 1'b0;
        end else begin
            if (cal_start) begin
                start_cyc = cyc;
                pulses    = 0;
                back2back = 1'b0;
            end
            if (load_taps) begin
                pulses++;
                if (prev_load) back2back = 1'b1;
            end
            prev_load = load_taps;
            if (cal_done && !prev_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected cal_done: got 1, expected 0");
                end else begin
                    e = sb.pop_front();
                    for (int k = 0; k < NL; k++)
                        checkOutput($sformatf("lane%0d tap", k), 64'(idelay_value[TW*k +: TW]),
                                    64'(e.taps[TW*k +: TW]));
                    checkOutput("cal_fail", 64'(cal_fail), 64'(e.fail));
                    checkOutput("load pulses", 64'(pulses), 64'd33);
                    checkOutput("no back-to-back load", 64'(back2back), 64'd0);
                    checkOutput("cal_busy in done", 64'(cal_busy), 64'd0);
                    if (e.timed) checkOutput("sweep cycles", 64'(cyc - start_cyc), 64'd834);
                end
            end
            prev_done = cal_done;
        end
    end

    task automatic applyStimulus(input logic poke_ovr);
        int i;
        sb.push_back(modelSweep());
        @(negedge clk) cal_start = 1'b1;
        @(negedge clk) cal_start = 1'b0;
`ifdef ERX_IDELAY_CAL_OVERRIDE_EN
        if (poke_ovr) begin
            ovr_taps = 45'h1;
            repeat (20) @(negedge clk);
            ovr_en = 1'b1;
            repeat (5) @(negedge clk);
            ovr_en = 1'b0;
        end
`else
        if (poke_ovr) @(negedge clk);
`endif
        i = 0;
        while (sb.size() != 0 && i < 3000) begin
            @(negedge clk);
            i++;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("[TB] FAIL sweep timeout: got no cal_done, expected cal_done within 3000 cycles");
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic setAll(input logic [31:0] m);
        for (int k = 0; k < NL; k++) pass_mask[k] = m;
    endtask

    initial begin
        int i;
        nreset    = 1'b0;
        cal_start = 1'b0;
        setAll('1);
        for (int k = 0; k < NL; k++) ch_tap[k] = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset idelay_value", 64'(idelay_value), 64'd0);
        checkOutput("reset load_taps", 64'(load_taps), 64'd0);
        checkOutput("reset cal_busy", 64'(cal_busy), 64'd0);
        checkOutput("reset cal_done", 64'(cal_done), 64'd0);
        checkOutput("reset cal_fail", 64'(cal_fail), 64'd0);
        nreset = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] full eye on every lane");
        setAll('1);
        applyStimulus(1'b0);

        $display("[TB] lane 3 narrow/offset window");
        setAll(win(10, 20));
        pass_mask[3] = win(5, 14);
        applyStimulus(1'b0);

        $display("[TB] lane 0 two windows, then tie");
        setAll('1);
        pass_mask[0] = win(2, 4) | win(20, 27);
        applyStimulus(1'b0);
        pass_mask[0] = win(2, 5) | win(20, 23);
        applyStimulus(1'b0);

        $display("[TB] frame lane never matches");
        setAll('1);
        pass_mask[8] = '0;
        applyStimulus(1'b0);

        $display("[TB] randomized windows with gapped cal_valid");
        valid_pct = 70;
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < NL; k++) begin
                pass_mask[k] = '0;
                for (int w = $urandom_range(0, 3); w > 0; w--) begin
                    int lo = $urandom_range(0, NT - 1);
                    pass_mask[k] |= win(lo, lo + $urandom_range(0, 11));
                end
            end
            applyStimulus(1'b0);
        end
        valid_pct = 100;

        $display("[TB] reset during CHECK at tap 7");
        setAll('1);
        @(negedge clk) cal_start = 1'b1;
        @(negedge clk) cal_start = 1'b0;
        i = 0;
        while (!(load_taps && cal_busy && idelay_value[TW-1:0] == 5'd7) && i < 1000) begin
            @(negedge clk);
            i++;
        end
        checkOutput("reached tap 7", 64'(i < 1000), 64'd1);
        repeat (12) @(negedge clk);
        nreset = 1'b0;
        #1;
        checkOutput("mid-sweep reset idelay_value", 64'(idelay_value), 64'd0);
        checkOutput("mid-sweep reset busy", 64'(cal_busy), 64'd0);
        checkOutput("mid-sweep reset done/load/fail", 64'({cal_done, load_taps, cal_fail}), 64'd0);
        @(negedge clk) nreset = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("idle after reset", 64'({cal_busy, load_taps, cal_done}), 64'd0);
        applyStimulus(1'b0);

`ifdef ERX_IDELAY_CAL_OVERRIDE_EN
        $display("[TB] manual override");
        begin
            int np = 0;
            ovr_taps = 45'h1;
            @(negedge clk) ovr_en = 1'b1;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                if (load_taps) np++;
            end
            ovr_en = 1'b0;
            checkOutput("override pulses", 64'(np), 64'd1);
            checkOutput("override idelay_value", 64'(idelay_value), 64'h1);
            checkOutput("override keeps cal_done", 64'(cal_done), 64'd1);
            checkOutput("override cal_fail", 64'(cal_fail), 64'd0);
        end
        setAll(win(3, 12));
        applyStimulus(1'b1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
